// File: rtl/neuron_pkg.sv
// Shared types and helpers for the single-neuron MAC sequencer.
package neuron_pkg;

   typedef enum logic [2:0] {CLEAR, FEED, DRAIN1, DRAIN2, HOLD} state_t;

   localparam int W_DATA_DEF = 8;
   localparam int W_ACC_DEF  = 16;
   localparam int RELU_MAX   = 127;

   // Clamp a signed sum into the 0..RELU_MAX activation range.
   function automatic int relu_sat(input int s);
      if (s < 0)        return 0;
      if (s > RELU_MAX) return RELU_MAX;
      return s;
   endfunction

endpackage

// File: rtl/neuron_seq_if.sv
// Bundles weight-write, input stream, MAC drive and result port of neuron_seq.
interface neuron_seq_if #(
   parameter int N_INPUTS = 4,
   parameter int W_DATA   = neuron_pkg::W_DATA_DEF,
   parameter int W_ACC    = neuron_pkg::W_ACC_DEF
);
   localparam int W_ADDR = $clog2(N_INPUTS);

   logic              w_wr_en;
   logic [W_ADDR-1:0] w_wr_addr;
   logic [W_DATA-1:0] w_wr_data;
   logic              in_valid;
   logic              in_ready;
   logic [W_DATA-1:0] in_data;
   logic              mac_rst_n;
   logic [W_DATA-1:0] mac_weight;
   logic [W_DATA-1:0] mac_x;
   logic [W_ACC-1:0]  mac_out;
   logic              res_valid;
   logic              res_ready;
   logic [W_ACC-1:0]  res_raw;
   logic [W_DATA-1:0] res_data;

   modport master (
      output w_wr_en, w_wr_addr, w_wr_data, in_valid, in_data, mac_out, res_ready,
      input  in_ready, mac_rst_n, mac_weight, mac_x, res_valid, res_raw, res_data
   );

   modport slave (
      input  w_wr_en, w_wr_addr, w_wr_data, in_valid, in_data, mac_out, res_ready,
      output in_ready, mac_rst_n, mac_weight, mac_x, res_valid, res_raw, res_data
   );

endinterface

// File: rtl/neuron_wbuf.sv
// Weight register file: synchronous write and clear, combinational read.
module neuron_wbuf #(
   parameter int N_INPUTS = 4,
   parameter int W_DATA   = 8,
   parameter int W_ADDR   = $clog2(N_INPUTS)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [W_ADDR-1:0] wr_addr,
   input  logic [W_DATA-1:0] wr_data,
   input  logic [W_ADDR-1:0] rd_addr,
   output logic [W_DATA-1:0] rd_data
);

   logic [N_INPUTS-1:0][W_DATA-1:0] mem;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mem <= '0;
      end else begin
         for (int i = 0; i < N_INPUTS; i++) begin
            if (wr_en && wr_addr == W_ADDR'(i)) mem[i] <= wr_data;
         end
      end
   end

   // Read sees pre-edge contents, so a same-cycle write does not affect the beat.
   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/neuron_seq.sv
// Feeds one vector through an external MAC, clears it between vectors, returns raw and ReLU result.
module neuron_seq
   import neuron_pkg::*;
#(
   parameter int N_INPUTS = 4,
   parameter int W_DATA   = W_DATA_DEF,
   parameter int W_ACC    = W_ACC_DEF
) (
   input logic         clk,
   input logic         rst_n,
   neuron_seq_if.slave bus
);

   localparam int W_ADDR = $clog2(N_INPUTS);
   localparam logic [W_ADDR-1:0] LAST = W_ADDR'(N_INPUTS - 1);

   state_t             state, state_nx;
   logic [W_ADDR-1:0]  idx, idx_nx;
   logic [W_DATA-1:0]  w_rd, weight_nx, x_nx;
   logic               beat, mac_rst_n_nx, res_valid_nx, capture;
   logic signed [W_ACC-1:0] acc_s;

   neuron_wbuf #(.N_INPUTS(N_INPUTS), .W_DATA(W_DATA), .W_ADDR(W_ADDR)) u_wbuf (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (bus.w_wr_en),
      .wr_addr (bus.w_wr_addr),
      .wr_data (bus.w_wr_data),
      .rd_addr (idx),
      .rd_data (w_rd)
   );

   assign bus.in_ready = (state == FEED);
   assign beat         = bus.in_valid && (state == FEED);
   assign acc_s        = bus.mac_out;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= CLEAR;
         idx   <= '0;
      end else begin
         state <= state_nx;
         idx   <= idx_nx;
      end
   end

   always_comb begin
      state_nx = state;
      idx_nx   = idx;
      case (state)
         CLEAR: begin
            state_nx = FEED;
            idx_nx   = '0;
         end
         FEED: begin
            if (beat) begin
               if (idx == LAST) begin
                  state_nx = DRAIN1;
                  idx_nx   = '0;
               end else begin
                  idx_nx = idx + 1'b1;
               end
            end
         end
         DRAIN1:  state_nx = DRAIN2;
         DRAIN2:  state_nx = HOLD;
         HOLD:    if (bus.res_ready) state_nx = CLEAR;
         default: state_nx = CLEAR;
      endcase
   end

   // Registered outputs are decoded from the next state, so mac_rst_n is low exactly while in CLEAR.
   always_comb begin
      mac_rst_n_nx = (state_nx != CLEAR);
      weight_nx    = beat ? w_rd : '0;
      x_nx         = beat ? bus.in_data : '0;
      res_valid_nx = (state_nx == HOLD);
      capture      = (state == DRAIN2);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bus.mac_rst_n  <= 1'b0;
         bus.mac_weight <= '0;
         bus.mac_x      <= '0;
         bus.res_valid  <= 1'b0;
         bus.res_raw    <= '0;
         bus.res_data   <= '0;
      end else begin
         bus.mac_rst_n  <= mac_rst_n_nx;
         bus.mac_weight <= weight_nx;
         bus.mac_x      <= x_nx;
         bus.res_valid  <= res_valid_nx;
         if (capture) begin
            bus.res_raw  <= bus.mac_out;
            bus.res_data <= W_DATA'(relu_sat(int'(acc_s)));
         end
      end
   end

endmodule

// File: tb/tb_neuron_seq.sv
// Scoreboard bench for neuron_seq with a behavioural MAC closing the loop.
module tb_neuron_seq;

   localparam int N = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   neuron_seq_if #(.N_INPUTS(N), .W_DATA(8), .W_ACC(16)) bus ();

   neuron_seq #(.N_INPUTS(N), .W_DATA(8), .W_ACC(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      int raw;
      int data;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_err = 0;
   int   cyc = 0;
   int   last_k = 0;
   int   wm[N];
   logic got = 1'b0;

   // Behavioural MAC: registered accumulate, synchronous clear.
   logic signed [15:0] acc;
   logic signed [7:0]  mw, mx;
   assign mw = bus.mac_weight;
   assign mx = bus.mac_x;
   assign bus.mac_out = acc;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (!bus.mac_rst_n) acc <= '0;
      else                acc <= acc + mw * mx;
   end

   task automatic chk(input string tag, input longint obs, input longint exp);
      n_cmp++;
      if (obs != exp) begin
         n_err++;
         $display("FAIL %s: got %0d want %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (!bus.res_valid) begin
         got = 1'b0;
      end else if (!got) begin
         got = 1'b1;
         if (sb.size() == 0) begin
            chk("unexpected_res", 1, 0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("res_raw", longint'($signed(bus.res_raw)), e.raw);
            chk("res_data", bus.res_data, e.data);
            chk("latency", cyc - last_k, 2);
         end
      end
   end

   task automatic check_rst(input string tag);
      chk({tag, "_mac_rst_n"}, bus.mac_rst_n, 0);
      chk({tag, "_mac_weight"}, bus.mac_weight, 0);
      chk({tag, "_mac_x"}, bus.mac_x, 0);
      chk({tag, "_res_valid"}, bus.res_valid, 0);
      chk({tag, "_res_raw"}, bus.res_raw, 0);
      chk({tag, "_res_data"}, bus.res_data, 0);
      chk({tag, "_in_ready"}, bus.in_ready, 0);
   endtask

   task automatic wr_w(input int i, input int v);
      @(negedge clk);
      bus.w_wr_en   = 1'b1;
      bus.w_wr_addr = 2'(i);
      bus.w_wr_data = 8'(v);
      @(posedge clk);
      #1;
      bus.w_wr_en = 1'b0;
      wm[i] = v;
   endtask

   task automatic set_w(input int ws[N]);
      for (int i = 0; i < N; i++) wr_w(i, ws[i]);
   endtask

   task automatic push_exp(input int xs[N]);
      int s;
      logic signed [15:0] s16;
      exp_t e;
      s = 0;
      for (int i = 0; i < N; i++) s += wm[i] * xs[i];
      s16 = 16'(s);
      e.raw  = int'(s16);
      e.data = (e.raw < 0) ? 0 : ((e.raw > 127) ? 127 : e.raw);
      sb.push_back(e);
   endtask

   task automatic beat(input int x, input bit wr = 1'b0, input int wi = 0, input int wv = 0);
      int t;
      t = 0;
      @(negedge clk);
      while (!bus.in_ready && t < 40) begin
         @(negedge clk);
         t++;
      end
      if (!bus.in_ready) chk("in_ready_timeout", 0, 1);
      bus.in_valid = 1'b1;
      bus.in_data  = 8'(x);
      if (wr) begin
         bus.w_wr_en   = 1'b1;
         bus.w_wr_addr = 2'(wi);
         bus.w_wr_data = 8'(wv);
      end
      @(posedge clk);
      #1;
      last_k = cyc;
      bus.in_valid = 1'b0;
      bus.w_wr_en  = 1'b0;
      if (wr) wm[wi] = wv;
   endtask

   task automatic send_vec(input int xs[N], input int gap);
      push_exp(xs);
      for (int i = 0; i < N; i++) begin
         beat(xs[i]);
         if (i < N - 1) begin
            for (int j = 0; j < gap; j++) begin
               @(posedge clk);
               #1;
               chk("bubble_mac_x", bus.mac_x, 0);
               chk("bubble_mac_weight", bus.mac_weight, 0);
            end
         end
      end
   endtask

   task automatic wait_drain();
      int t;
      t = 0;
      while (sb.size() != 0 && t < 30) begin
         @(negedge clk);
         t++;
      end
      if (sb.size() != 0) begin
         chk("result_timeout", sb.size(), 0);
         sb.delete();
      end
   endtask

   initial begin
      bus.w_wr_en   = 1'b0;
      bus.w_wr_addr = '0;
      bus.w_wr_data = '0;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.res_ready = 1'b1;
      for (int i = 0; i < N; i++) wm[i] = 0;

      repeat (2) @(posedge clk);
      @(negedge clk);
      check_rst("reset");
      rst_n = 1'b1;

      // Saturating positive sum, back-to-back beats.
      set_w('{2, 64, 1, 2});
      send_vec('{2, 64, 0, 1}, 0);
      wait_drain();

      // Negative sum clamps to zero.
      set_w('{-127, -127, -127, -127});
      send_vec('{1, 1, 1, 1}, 0);
      wait_drain();

      // Bubbles between beats.
      set_w('{1, 1, 1, 1});
      send_vec('{10, 20, -5, 3}, 2);
      wait_drain();

      // Backpressure on the result port, then vector isolation.
      @(negedge clk);
      bus.res_ready = 1'b0;
      send_vec('{1, 2, 3, 4}, 0);
      wait_drain();
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = 8'd9;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_in_ready", bus.in_ready, 0);
         chk("bp_res_raw", longint'($signed(bus.res_raw)), 10);
         chk("bp_res_valid", bus.res_valid, 1);
      end
      bus.in_valid = 1'b0;
      set_w('{127, 127, 0, 0});
      @(negedge clk);
      bus.res_ready = 1'b1;
      @(negedge clk);
      chk("clear_mac_rst_n", bus.mac_rst_n, 0);
      chk("clear_res_valid", bus.res_valid, 0);
      chk("clear_in_ready", bus.in_ready, 0);
      @(negedge clk);
      chk("feed_mac_rst_n", bus.mac_rst_n, 1);
      send_vec('{1, 1, 1, 1}, 0);
      wait_drain();

      // Reset mid-vector discards progress and weights.
      beat(1);
      beat(1);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check_rst("midrst");
      for (int i = 0; i < N; i++) wm[i] = 0;
      rst_n = 1'b1;
      send_vec('{1, 1, 1, 1}, 0);
      wait_drain();
      set_w('{3, 3, 3, 3});
      send_vec('{1, 2, 3, 4}, 0);
      wait_drain();

      // Weight write in the same cycle as the beat that reads it.
      set_w('{1, 1, 1, 1});
      push_exp('{1, 0, 0, 0});
      beat(1, 1'b1, 0, 5);
      beat(0);
      beat(0);
      beat(0);
      wait_drain();
      send_vec('{1, 0, 0, 0}, 0);
      wait_drain();

      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
